// File: rtl/conv_window_pe.sv
// conv_window_pe: tracks a raster pixel stream and captures a KxK window
// anchored at a programmable (row, col). It forwards the stream through a
// one-stage registered bypass and drains the window in raster order.
//
// Handshake: a window word moves when out_valid && out_ready are both high
// on a rising edge. out_valid stays high and out_data/out_last stay stable
// until the word is taken. out_valid never depends on out_ready.
module conv_window_pe #(
   parameter int W     = 8,
   parameter int K     = 5,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int CW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] id_row,
   input  logic [CW-1:0] id_col,
   input  logic          in_valid,
   input  logic [W-1:0]  indata,
   output logic [W-1:0]  bypass,
   output logic          bypass_valid,
   output logic          win_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_last,
   output logic          done,
   output logic [1:0]    dbg_state
);

   localparam int NS = K * K;
   localparam int PW = (NS > 1) ? $clog2(NS) : 1;
   localparam int EW = CW + 1;
   localparam logic [EW-1:0] K_E      = EW'(K);
   localparam logic [EW-1:0] ONE_E    = EW'(1);
   localparam logic [EW-1:0] LAST_ROW = EW'(IMG_H - 1);
   localparam logic [EW-1:0] LAST_COL = EW'(IMG_W - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(NS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   row_q, col_q, idr_q, idc_q;
   logic [PW-1:0]   ptr_q;
   logic [W-1:0]    mem [NS];

   logic            capture_fire, in_win, complete, accept;
   logic [EW-1:0]   p_row, p_col, w_row, w_col, dr, dc;
   logic [PW-1:0]   slot;

   // Current pixel position and window anchor; start forces position (0,0)
   // and uses the freshly presented anchor so a concurrent pixel is handled.
   always_comb begin
      capture_fire = in_valid && (start || (state_q == CAPTURE));
      p_row  = start ? '0 : {1'b0, row_q};
      p_col  = start ? '0 : {1'b0, col_q};
      w_row  = start ? {1'b0, id_row} : {1'b0, idr_q};
      w_col  = start ? {1'b0, id_col} : {1'b0, idc_q};
      in_win = (p_row >= w_row) && (p_row < w_row + K_E) &&
               (p_col >= w_col) && (p_col < w_col + K_E);
      dr     = p_row - w_row;
      dc     = p_col - w_col;
      slot   = PW'((32'(dr) * 32'(K)) + 32'(dc));
      complete = capture_fire &&
                 (((p_row == w_row + K_E - ONE_E) && (p_col == w_col + K_E - ONE_E)) ||
                  ((p_row == LAST_ROW) && (p_col == LAST_COL)));
      accept = (state_q == DRAIN) && out_ready;
   end

   // Next-state selection; start overrides everything except reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         CAPTURE: if (complete) state_d = DRAIN;
         DRAIN:   if (accept && (ptr_q == PTR_LAST)) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (start) state_d = complete ? DRAIN : CAPTURE;
   end

   // Outputs decoded from state so reset and restart clear them together.
   always_comb begin
      out_valid = (state_q == DRAIN);
      out_last  = out_valid && (ptr_q == PTR_LAST);
      out_data  = out_valid ? mem[ptr_q] : '0;
      win_ready = (state_q == DRAIN) || (state_q == DONE);
      done      = (state_q == DONE);
      dbg_state = state_q;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Anchor, frame position counters and read pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
         idr_q <= '0;
         idc_q <= '0;
         ptr_q <= '0;
      end else begin
         if (start) begin
            idr_q <= id_row;
            idc_q <= id_col;
            row_q <= '0;
            col_q <= '0;
            ptr_q <= '0;
         end
         if (capture_fire) begin
            if (p_col == LAST_COL) begin
               col_q <= '0;
               row_q <= CW'(p_row + ONE_E);
            end else begin
               col_q <= CW'(p_col + ONE_E);
               row_q <= p_row[CW-1:0];
            end
         end
         if (accept && !start)
            ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
      end
   end

   // Window storage: zeroed on start so off-image slots read back as 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (start)
            for (int i = 0; i < NS; i++) mem[i] <= '0;
         if (capture_fire && in_win)
            mem[slot] <= indata;
      end
   end

   // One-stage bypass toward the next PE, active in every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         bypass       <= '0;
         bypass_valid <= 1'b0;
      end else begin
         bypass       <= indata;
         bypass_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_conv_window_pe.sv
// tb_conv_window_pe: scenario tasks for conv_window_pe (K=5, 32x32 image).
module tb_conv_window_pe;

  localparam int W  = 8;
  localparam int K  = 5;
  localparam int NS = K * K;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] id_row = '0;
  logic [CW-1:0] id_col = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  indata = '0;
  logic [W-1:0]  bypass;
  logic          bypass_valid;
  logic          win_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          done;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  conv_window_pe #(.W(W), .K(K), .IMG_W(32), .IMG_H(32)) dut (
    .clk(clk), .rst(rst), .start(start), .id_row(id_row), .id_col(id_col),
    .in_valid(in_valid), .indata(indata), .bypass(bypass),
    .bypass_valid(bypass_valid), .win_ready(win_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // bypass monitor: output after each edge equals the input sampled at it
  logic [W-1:0] m_d;
  logic         m_v;
  always @(posedge clk) begin
    if (mon_en) begin
      m_v = rst ? 1'b0 : in_valid;
      m_d = rst ? '0 : indata;
      #1;
      checks++;
      if (bypass_valid !== m_v || bypass !== m_d) begin
        errors++;
        $display("FAIL bypass: got v=%b d=%0d, want v=%b d=%0d", bypass_valid, bypass, m_v, m_d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: expected window for anchor (r,c), pixel = (index + off) mod 256
  task automatic push_window(input int r, input int c, input int off);
    exp_q.delete();
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        if (r + i < 32 && c + j < 32) exp_q.push_back(W'(((r + i) * 32 + (c + j) + off) % 256));
        else exp_q.push_back('0);
      end
  endtask

  task automatic do_start(input int r, input int c);
    start = 1'b1; id_row = CW'(r); id_col = CW'(c); in_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // feed pixels 0..last_idx; win_ready must rise exactly after last_idx when expected
  task automatic feed(input int last_idx, input int off, input bit toggle,
                      input bit with_start, input int sr, input int sc, input bit exp_complete);
    logic exp_wr;
    for (int i = 0; i <= last_idx; i++) begin
      in_valid = 1'b1;
      indata = W'((i + off) % 256);
      if (with_start && i == 0) begin
        start = 1'b1; id_row = CW'(sr); id_col = CW'(sc);
      end
      tick();
      start = 1'b0;
      exp_wr = exp_complete && (i == last_idx);
      checks++;
      if (win_ready !== exp_wr) begin
        errors++;
        $display("FAIL win_ready after pixel %0d: got %b want %b", i, win_ready, exp_wr);
      end
      if (toggle) begin
        in_valid = 1'b0;
        indata = W'($urandom_range(0, 255));
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  // drain n words against the scoreboard; optional stall every third cycle
  task automatic drain(input int n, input bit stall, input bit exp_done);
    int cyc, got;
    logic [W-1:0] e, held;
    bit was_stall;
    cyc = 0; got = 0; was_stall = 1'b0; held = '0;
    while (got < n && cyc < 400) begin
      out_ready = stall ? ((cyc % 3) != 2) : 1'b1;
      if (was_stall) begin
        checks++;
        if (out_data !== held || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, held);
        end
        was_stall = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          if (got == 0) begin
            checks++;
            if (done !== 1'b0) begin
              errors++;
              $display("FAIL done_early: got %b want 0", done);
            end
          end
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got data %0d want none", out_data);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e) begin
              errors++;
              $display("FAIL out_data[%0d]: got %0d want %0d", got, out_data, e);
            end
            checks++;
            if (out_last !== 1'(got == NS - 1)) begin
              errors++;
              $display("FAIL out_last[%0d]: got %b want %b", got, out_last, (got == NS - 1));
            end
          end
          got++;
        end else begin
          was_stall = 1'b1;
          held = out_data;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words want %0d", got, n);
    end
    if (exp_done) begin
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || win_ready !== 1'b1) begin
        errors++;
        $display("FAIL done_after_drain: got done=%b ov=%b wr=%b want 1 0 1", done, out_valid, win_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bypass, bypass_valid, win_ready, out_valid, out_last, out_data, done, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state: got byp=%0d bv=%b wr=%b ov=%b ol=%b od=%0d dn=%b st=%0d want all 0",
               bypass, bypass_valid, win_ready, out_valid, out_last, out_data, done, dbg_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_start(1, 2);
    push_window(1, 2, 0);
    feed(166, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    drain(NS, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    push_window(1, 2, 0);
    feed(166, 0, 1'b1, 1'b1, 1, 2, 1'b1);
    drain(NS, 1'b1, 1'b1);
  endtask

  task automatic test_edge();
    do_start(30, 30);
    push_window(30, 30, 0);
    feed(1023, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    drain(NS, 1'b0, 1'b1);
  endtask

  task automatic test_restart_capture();
    do_start(1, 2);
    feed(50, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    push_window(1, 2, 100);
    feed(166, 100, 1'b0, 1'b1, 1, 2, 1'b1);
    drain(NS, 1'b0, 1'b1);
  endtask

  task automatic test_restart_drain();
    do_start(1, 2);
    push_window(1, 2, 0);
    feed(166, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    drain(7, 1'b0, 1'b0);
    out_ready = 1'b0;
    do_start(0, 0);
    checks++;
    if (out_valid !== 1'b0 || win_ready !== 1'b0 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL start_in_drain: got ov=%b wr=%b st=%0d want 0 0 1", out_valid, win_ready, dbg_state);
    end
    push_window(0, 0, 50);
    feed(132, 50, 1'b0, 1'b0, 0, 0, 1'b1);
    drain(NS, 1'b0, 1'b1);
  endtask

  task automatic test_rst_drain();
    do_start(2, 3);
    push_window(2, 3, 0);
    feed(199, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    drain(10, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    indata = 8'hA5;
    tick();
    checks++;
    if ({bypass, bypass_valid, win_ready, out_valid, out_last, out_data, done, dbg_state} !== '0) begin
      errors++;
      $display("FAIL rst_mid_drain: got byp=%0d bv=%b wr=%b ov=%b ol=%b od=%0d dn=%b st=%0d want all 0",
               bypass, bypass_valid, win_ready, out_valid, out_last, out_data, done, dbg_state);
    end
    rst = 1'b0;
    feed(200, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (dbg_state !== 2'd0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL no_capture_without_start: got st=%0d ov=%b dn=%b want 0 0 0", dbg_state, out_valid, done);
    end
  endtask

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_edge();
    test_restart_capture();
    test_restart_drain();
    test_rst_drain();
    tick();
    mon_en = 1'b0;
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_pe.md
# conv_window_pe

Parametrised processing element for the CNN systolic chain. It watches a raster-ordered pixel stream, captures a K×K convolution window anchored at a programmable (row, col) position into local registers, and forwards the stream to the next PE through a registered bypass. Once the window is complete, it drains the window in raster order over a valid/ready handshake. Unlike the fixed 5×5, 32-wide PE, it keeps its own frame position counters, zero-pads windows that cross the image edge, and signals completion explicitly.

## Interface
- W, default 8: pixel data width.
- K, default 5: window side; storage is K*K words of W bits.
- IMG_W, default 32: image width in pixels.
- IMG_H, default 32: image height in pixels.
- CW, default $clog2(max(IMG_W,IMG_H)): width of row and column indices.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a new frame: clears the window, position counters and pointer, then enters CAPTURE.
- id_row  in  CW  window top row; sampled on start.
- id_col  in  CW  window left column; sampled on start.
- in_valid  in  1  indata carries the next raster pixel.
- indata  in  W  pixel value.
- bypass  out  W  indata delayed by one register stage.
- bypass_valid  out  1  in_valid delayed by one register stage.
- win_ready  out  1  window complete; stays high until start or rst.
- out_valid  out  1  out_data is valid (DRAIN state).
- out_ready  in  1  downstream accepts out_data.
- out_data  out  W  window pixel at the current read pointer.
- out_last  out  1  high with the final (K*K-1) pixel.
- done  out  1  drain finished; stays high until start or rst.

## Operation
- States:
  - IDLE: wait for start.
  - CAPTURE: count and capture window pixels.
  - DRAIN: output the window over the handshake.
  - DONE: hold done.
- Transitions:
  - IDLE→CAPTURE on start.
  - CAPTURE→DRAIN when the window is complete.
  - DRAIN→DONE when the last pixel is accepted (out_valid && out_ready && out_last).
  - start in any state restarts CAPTURE. rst returns to IDLE.
- CAPTURE position tracking:
  - col/row counters advance on each in_valid.
  - col wraps at IMG_W-1 and row increments at the wrap.
  - The pixel at (row, col) is stored to slot (row-id_row)*K + (col-id_col) when id_row ≤ row < id_row+K and id_col ≤ col < id_col+K.
  - Comparisons use CW+1-bit unsigned arithmetic, so id+K never overflows.
- Window completion, whichever comes first:
  - the pixel at (id_row+K-1, id_col+K-1) is accepted; or
  - the last frame pixel (IMG_H-1, IMG_W-1) is accepted.
- Edge handling: slots outside the image are never written and keep the 0 loaded at start.
- After completion, further in_valid pixels are bypassed only. Position counters stop, and nothing is captured outside CAPTURE.
- Bypass runs in every state, including IDLE and DONE.
- Readout:
  - A read pointer 0..K*K-1 drives out_data = slot[ptr].
  - The pointer advances on out_valid && out_ready.
  - out_last = (ptr == K*K-1).

## Timing
- Reset values: bypass = 0, bypass_valid = 0, win_ready = 0, out_valid = 0, out_last = 0, out_data = 0, done = 0. State IDLE, all counters 0. Storage is cleared on start, not on rst.
- Bypass latency: exactly 1 cycle, including a 1-cycle delay of bypass_valid.
- A pixel accepted at edge n is stored at edge n. When that pixel completes the window, win_ready and out_valid rise after edge n, i.e. in cycle n+1.
- Drain throughput: one pixel per cycle while out_ready=1. With out_ready=0, out_data and ptr hold and out_valid stays high.
- done rises in the cycle after the accepting edge of the last pixel. out_valid falls in the same cycle.
- start concurrent with in_valid: the counters load 0 and that pixel is treated as frame pixel (0,0).
- start during DRAIN: out_valid falls next cycle, the window is discarded, and capture restarts.
- rst mid-operation: all outputs take their reset values the next cycle.

## Test plan
- K=5, IMG 32×32, id=(1,2), indata = pixel index mod 256, continuous in_valid -> win_ready rises the cycle after pixel 166. Drain with out_ready=1 yields 34,35,36,37,38,66,…,166; out_last on 166; done one cycle later.
- Same stream with in_valid toggling 1/0 and out_ready low every third cycle -> identical 25-value sequence; no duplicated or dropped values; out_data stable while stalled.
- id=(30,30) -> completes after pixel 1023. Drain gives 222,223,0,0,0,254,255,0,… and zeros for every off-image slot.
- bypass check across all states -> bypass(t+1) = indata(t) and bypass_valid(t+1) = in_valid(t) for every cycle.
- start asserted mid-CAPTURE after pixel 50, then a fresh frame -> the window contains only new-frame values. start at drain pointer 7 -> out_valid low next cycle, then a full re-capture.
- rst asserted at drain pointer 10 -> all outputs 0 next cycle and state IDLE; in_valid without start produces no capture.
